// File: rtl/store_monitor.sv
// Pass/fail monitor on the data-memory write port: PASS on the signature store,
// FAIL on stray stores, bad signature data, early signature or timeout.
module store_monitor #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int PASS_ADDR  = 100,
    parameter int PASS_DATA  = 25,
    parameter int SCR_LO     = 96,
    parameter int SCR_HI     = 96,
    parameter int MIN_STORES = 0,
    parameter int TIMEOUT    = 10000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [2:0]        fail_code,
    output logic [15:0]       store_count,
    output logic [31:0]       cycle_count,
    output logic [ADDR_W-1:0] last_adr,
    output logic [DATA_W-1:0] last_data
);
    localparam logic [ADDR_W-1:0] P_ADDR  = ADDR_W'(PASS_ADDR);
    localparam logic [DATA_W-1:0] P_DATA  = DATA_W'(PASS_DATA);
    localparam logic [ADDR_W-1:0] S_LO    = ADDR_W'(SCR_LO);
    localparam logic [ADDR_W-1:0] S_HI    = ADDR_W'(SCR_HI);
    localparam logic [15:0]       MIN_CNT = 16'(MIN_STORES);
    localparam logic [31:0]       TO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, PASSED, FAILED} state_t;

    state_t     state, state_n;
    logic [2:0] code_n;
    logic       scr_hit;
    logic       timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cycle_count == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fail_code <= 3'd0;
        end else begin
            state     <= state_n;
            fail_code <= code_n;
        end
    end

    always_comb begin
        state_n = state;
        code_n  = fail_code;
        scr_hit = 1'b0;
        case (state)
            IDLE: if (start) state_n = RUN;
            RUN: begin
                if (!start) begin
                    if (mem_write) begin
                        if (data_adr == P_ADDR && write_data == P_DATA) begin
                            if (store_count >= MIN_CNT) begin
                                state_n = PASSED;
                            end else begin
                                state_n = FAILED;
                                code_n  = 3'd4;
                            end
                        end else if (data_adr == P_ADDR) begin
                            state_n = FAILED;
                            code_n  = 3'd2;
                        end else if (data_adr >= S_LO && data_adr <= S_HI) begin
                            scr_hit = 1'b1;
                        end else begin
                            state_n = FAILED;
                            code_n  = 3'd1;
                        end
                    end
                    // a store verdict on the timeout edge takes precedence
                    if (state_n == RUN && timeout_hit) begin
                        state_n = FAILED;
                        code_n  = 3'd3;
                    end
                end
            end
            PASSED, FAILED: if (start) state_n = RUN;
            default: state_n = IDLE;
        endcase
        if (start) code_n = 3'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_count <= 16'd0;
            cycle_count <= 32'd0;
            last_adr    <= '0;
            last_data   <= '0;
        end else if (start) begin
            store_count <= 16'd0;
            cycle_count <= 32'd0;
            last_adr    <= '0;
            last_data   <= '0;
        end else if (state == RUN) begin
            if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
            if (mem_write) begin
                last_adr  <= data_adr;
                last_data <= write_data;
            end
            if (scr_hit && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
        end
    end

    assign pass = (state == PASSED);
    assign fail = (state == FAILED);
    assign done = pass | fail;
endmodule
